// File: rtl/ux607_icb2axi_pkg.sv
// rtl/ux607_icb2axi_pkg.sv - shared AXI constants and helpers for the ICB-to-AXI bridge
// Purpose: AXI encodings used by the bridge plus a constant clog2 for pointer sizing.
// Ports: none (package).
package ux607_icb2axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [3:0] CACHE_DEF   = 4'b0011;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Ceiling log2 usable in constant expressions; clog2(1) is 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ux607_subsys_icb2axi_if.sv
// rtl/ux607_subsys_icb2axi_if.sv - ICB and AXI4 bus interfaces for the ICB-to-AXI bridge
// Purpose: bundles the ICB command/response handshake and the five AXI4 channels.
// Ports (ICB):  icb_cmd_{valid,ready,read,addr,wdata,wmask,size}, icb_rsp_{valid,ready,err,rdata}
//   modport slave  - the side that accepts commands and returns responses (the bridge)
//   modport master - the initiator side
// Ports (AXI):  axi_ar*, axi_aw*, axi_w*, axi_r*, axi_b*
//   modport master - the side that issues AR/AW/W and consumes R/B (the bridge)
//   modport slave  - the downstream fabric side
interface ux607_icb2axi_icb_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MW = DW / 8
);
  logic          icb_cmd_valid;
  logic          icb_cmd_ready;
  logic          icb_cmd_read;
  logic [AW-1:0] icb_cmd_addr;
  logic [DW-1:0] icb_cmd_wdata;
  logic [MW-1:0] icb_cmd_wmask;
  logic [1:0]    icb_cmd_size;
  logic          icb_rsp_valid;
  logic          icb_rsp_ready;
  logic          icb_rsp_err;
  logic [DW-1:0] icb_rsp_rdata;

  modport slave (
    input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
           icb_cmd_size, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );
  modport master (
    output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
           icb_cmd_size, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );
endinterface

interface ux607_icb2axi_axi_if #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int MW   = DW / 8,
  parameter int ID_W = 4
);
  logic            axi_arvalid, axi_arready, axi_arlock;
  logic [ID_W-1:0] axi_arid;
  logic [AW-1:0]   axi_araddr;
  logic [7:0]      axi_arlen;
  logic [2:0]      axi_arsize, axi_arprot;
  logic [1:0]      axi_arburst;
  logic [3:0]      axi_arcache;

  logic            axi_awvalid, axi_awready, axi_awlock;
  logic [ID_W-1:0] axi_awid;
  logic [AW-1:0]   axi_awaddr;
  logic [7:0]      axi_awlen;
  logic [2:0]      axi_awsize, axi_awprot;
  logic [1:0]      axi_awburst;
  logic [3:0]      axi_awcache;

  logic            axi_wvalid, axi_wready, axi_wlast;
  logic [DW-1:0]   axi_wdata;
  logic [MW-1:0]   axi_wstrb;

  logic            axi_rvalid, axi_rready, axi_rlast;
  logic [ID_W-1:0] axi_rid;
  logic [DW-1:0]   axi_rdata;
  logic [1:0]      axi_rresp;

  logic            axi_bvalid, axi_bready;
  logic [ID_W-1:0] axi_bid;
  logic [1:0]      axi_bresp;

  modport master (
    output axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
           axi_arlock, axi_arcache, axi_arprot,
           axi_awvalid, axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
           axi_awlock, axi_awcache, axi_awprot,
           axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
           axi_rready, axi_bready,
    input  axi_arready, axi_awready, axi_wready,
           axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
           axi_bvalid, axi_bid, axi_bresp
  );
  modport slave (
    input  axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
           axi_arlock, axi_arcache, axi_arprot,
           axi_awvalid, axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
           axi_awlock, axi_awcache, axi_awprot,
           axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
           axi_rready, axi_bready,
    output axi_arready, axi_awready, axi_wready,
           axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
           axi_bvalid, axi_bid, axi_bresp
  );
endinterface

// File: rtl/ux607_icb2axi_ord_fifo.sv
// rtl/ux607_icb2axi_ord_fifo.sv - 1-bit order FIFO tracking read/write type of outstanding commands
// Purpose: remembers, in command order, whether each outstanding transaction is a read.
// Ports: clk, rst (sync, active-high); push/push_rd write one entry; pop drops the head;
//        full/empty status; head_rd is the type of the oldest entry (1=read).
module ux607_icb2axi_ord_fifo
  import ux607_icb2axi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_rd,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head_rd
);

  localparam int PTR_W = clog2(DEPTH);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0] mem_q, mem_d;

  assign full    = (cnt_q == (PTR_W + 1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head_rd = mem_q[rptr_q];

  // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    mem_d  = mem_q;
    if (push) begin
      mem_d[wptr_q] = push_rd;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      mem_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/ux607_subsys_icb2axi.sv
// rtl/ux607_subsys_icb2axi.sv - ICB-to-AXI4 single-beat master bridge with in-order responses
// Purpose: turns ICB commands into single-beat AXI4 reads or writes and returns the
//          responses to ICB in command order, steering R/B by an order FIFO.
// Ports: clk, rst (sync, active-high)
//        icb - ICB slave side (command in, response out)
//        axi - AXI4 master side (AR/AW/W out, R/B in)
module ux607_subsys_icb2axi
  import ux607_icb2axi_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MW       = DW / 8,
  parameter int ID_W     = 4,
  parameter int OUTS_NUM = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ux607_icb2axi_icb_if.slave   icb,
  ux607_icb2axi_axi_if.master  axi
);

  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic full, empty, head_rd;
  logic cmd_fire, rsp_fire;

  ux607_icb2axi_ord_fifo #(
    .DEPTH (OUTS_NUM)
  ) u_ord_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd_fire),
    .push_rd (icb.icb_cmd_read),
    .pop     (rsp_fire),
    .full    (full),
    .empty   (empty),
    .head_rd (head_rd)
  );

  // Fixed single-beat transaction attributes; addr/data/strobe pass straight through.
  assign axi.axi_arid    = '0;
  assign axi.axi_araddr  = icb.icb_cmd_addr;
  assign axi.axi_arlen   = 8'd0;
  assign axi.axi_arsize  = {1'b0, icb.icb_cmd_size};
  assign axi.axi_arburst = BURST_INCR;
  assign axi.axi_arlock  = 1'b0;
  assign axi.axi_arcache = CACHE_DEF;
  assign axi.axi_arprot  = 3'b000;

  assign axi.axi_awid    = '0;
  assign axi.axi_awaddr  = icb.icb_cmd_addr;
  assign axi.axi_awlen   = 8'd0;
  assign axi.axi_awsize  = {1'b0, icb.icb_cmd_size};
  assign axi.axi_awburst = BURST_INCR;
  assign axi.axi_awlock  = 1'b0;
  assign axi.axi_awcache = CACHE_DEF;
  assign axi.axi_awprot  = 3'b000;

  assign axi.axi_wdata   = icb.icb_cmd_wdata;
  assign axi.axi_wstrb   = icb.icb_cmd_wmask;
  assign axi.axi_wlast   = 1'b1;

  // Command side. The ICB command is held stable until ready, so AW and W can each
  // complete early; the done flags stop re-issuing a channel that already handshook.
  always_comb begin
    axi.axi_arvalid   = 1'b0;
    axi.axi_awvalid   = 1'b0;
    axi.axi_wvalid    = 1'b0;
    icb.icb_cmd_ready = 1'b0;
    aw_done_d         = aw_done_q;
    w_done_d          = w_done_q;

    if (icb.icb_cmd_read) begin
      axi.axi_arvalid   = icb.icb_cmd_valid & ~full;
      icb.icb_cmd_ready = ~full & axi.axi_arready;
    end else begin
      axi.axi_awvalid   = icb.icb_cmd_valid & ~full & ~aw_done_q;
      axi.axi_wvalid    = icb.icb_cmd_valid & ~full & ~w_done_q;
      icb.icb_cmd_ready = ~full & (aw_done_q | axi.axi_awready) & (w_done_q | axi.axi_wready);
    end

    cmd_fire = icb.icb_cmd_valid & icb.icb_cmd_ready;

    if (cmd_fire) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (axi.axi_awvalid & axi.axi_awready) aw_done_d = 1'b1;
      if (axi.axi_wvalid & axi.axi_wready)   w_done_d  = 1'b1;
    end
  end

  // Response side. Only the channel matching the FIFO head is connected, so an R or B
  // that arrives out of command order waits on the AXI side until its turn.
  always_comb begin
    icb.icb_rsp_valid = 1'b0;
    icb.icb_rsp_err   = 1'b0;
    icb.icb_rsp_rdata = '0;
    axi.axi_rready    = 1'b0;
    axi.axi_bready    = 1'b0;
    if (!empty) begin
      if (head_rd) begin
        icb.icb_rsp_valid = axi.axi_rvalid;
        icb.icb_rsp_err   = axi.axi_rresp[1];
        icb.icb_rsp_rdata = axi.axi_rdata;
        axi.axi_rready    = icb.icb_rsp_ready;
      end else begin
        icb.icb_rsp_valid = axi.axi_bvalid;
        icb.icb_rsp_err   = axi.axi_bresp[1];
        axi.axi_bready    = icb.icb_rsp_ready;
      end
    end
    rsp_fire = icb.icb_rsp_valid & icb.icb_rsp_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // IDs are always 0, last is implied by single beats, and resp[0] does not affect err.
  logic unused_ok;
  assign unused_ok = ^{axi.axi_rid, axi.axi_rlast, axi.axi_bid,
                       axi.axi_rresp[0], axi.axi_bresp[0]};

endmodule

// File: doc/ux607_subsys_icb2axi.md
# ux607_subsys_icb2axi

ICB-to-AXI4 master bridge: accepts single-beat ICB commands from a subsystem initiator and issues single-beat AXI4 read (AR/R) or write (AW/W/B) transactions to a downstream AXI fabric. It returns the ICB responses in command order. It is the initiator-side counterpart of the subsystem's AXI-to-ICB SRAM slave path, so ICB-native masters can reach AXI targets.

## Interface
- AW, 32: address width
- DW, 32: data width (32 or 64)
- MW, DW/8: write-mask / strobe width
- ID_W, 4: AXI ID width; all transactions use ID 0
- OUTS_NUM, 4: maximum outstanding transactions (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset. Synchronous and active-high.
- icb_cmd_valid / icb_cmd_ready  in/out  1  ICB command handshake
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_addr  in  AW  byte address
- icb_cmd_wdata  in  DW  write data
- icb_cmd_wmask  in  MW  byte enables
- icb_cmd_size  in  2  log2 bytes
- icb_rsp_valid / icb_rsp_ready  out/in  1  ICB response handshake
- icb_rsp_err  out  1  response error
- icb_rsp_rdata  out  DW  read data; 0 for writes
- axi_ar{valid,ready,id,addr,len,size,burst,lock,cache,prot}  out (ready in)  std  read address channel
- axi_aw{valid,ready,id,addr,len,size,burst,lock,cache,prot}  out (ready in)  std  write address channel
- axi_w{valid,ready,data,strb,last}  out (ready in)  std  write data channel
- axi_r{valid,ready,id,data,resp,last}  in (ready out)  std  read data channel
- axi_b{valid,ready,id,resp}  in (ready out)  std  write response channel

## Operation
- Constant AXI fields:
  - len=0, burst=INCR(01), lock=0, cache=0011, prot=000, id=0, wlast=1.
  - size={1'b0,icb_cmd_size}.
  - addr, data and strobe are passed through unmodified.
- Order FIFO, OUTS_NUM deep, 1 bit per entry (1=read). An entry is pushed on ICB command acceptance and popped on ICB response handshake.
- full means the count equals OUTS_NUM. There is no bypass: ready uses the pre-pop count.
- Read command:
  - axi_arvalid = icb_cmd_valid & icb_cmd_read & ~full.
  - icb_cmd_ready = ~full & axi_arready.
- Write command:
  - Flags aw_done and w_done record early channel acceptance.
  - axi_awvalid = icb_cmd_valid & ~icb_cmd_read & ~full & ~aw_done. axi_wvalid is formed the same way with ~w_done.
  - icb_cmd_ready = ~full & (aw_done|axi_awready) & (w_done|axi_wready).
  - Both flags clear when the command is accepted.
- AW and W may complete in either order or in the same cycle. The bridge relies on ICB holding the command stable until ready.
- Response selection follows the FIFO head:
  - Head=read: icb_rsp_valid=axi_rvalid, axi_rready=icb_rsp_ready, rdata=axi_rdata.
  - Head=write: icb_rsp_valid=axi_bvalid, axi_bready=icb_rsp_ready.
  - When the FIFO is empty, icb_rsp_valid=0 and both readies are 0.
- icb_rsp_err = resp[1]. SLVERR and DECERR set it; OKAY and EXOKAY clear it.
- Any R or B response arriving for a non-head type stalls until its type reaches the head. Cross-channel reordering is therefore resolved.

## Timing
- Reset values: every AXI valid and ready is 0, icb_cmd_ready=0, icb_rsp_valid=0, FIFO is empty, aw_done=w_done=0.
- Command path is combinational: a read is accepted in the same cycle as arvalid&arready.
- Response path is combinational, with zero added latency from R/B to ICB rsp.
- Throughput is one command per cycle until OUTS_NUM is outstanding.
- Full plus a simultaneous response pop: the command is still blocked that cycle and accepted the next cycle.
- Counter wrap: the pointers are log2(OUTS_NUM) bits wide and wrap naturally. The count is log2(OUTS_NUM)+1 bits.
- Reset mid-transaction: the FIFO and flags clear and valids drop in the next cycle. The AXI side must be reset together with the bridge.

## Structure
- Package ux607_icb2axi_pkg holds:
  - AXI constants: BURST_INCR, CACHE_DEF, RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - The function clog2 used for pointer widths.
- Sub-module ux607_icb2axi_ord_fifo: a 1-bit synchronous FIFO with push/pop/full/empty/head outputs and a synchronous active-high reset.

## Test plan
- Single read to addr 0x100, size 2, slave returns data 0xDEADBEEF with OKAY → arvalid with araddr=0x100, arsize=2, arlen=0; icb_rsp_rdata=0xDEADBEEF, err=0.
- Write 0x12345678, mask 0xF: AW ready 3 cycles before W ready → awvalid drops after its handshake; cmd_ready pulses only in the W handshake cycle; B OKAY → rsp err=0.
- Write followed by read; slave returns R before B → read response held off until the write response is delivered; ICB order is write then read.
- OUTS_NUM=2, three back-to-back reads with no R → third cmd_ready=0. First R plus a new command in the same cycle → the third command is accepted the following cycle.
- Read answered with DECERR (resp=11) → icb_rsp_err=1. Write answered with SLVERR → icb_rsp_err=1.
- Assert rst for 1 cycle while 2 transactions are outstanding and aw_done=1 → all valids 0 and FIFO empty the next cycle; a subsequent fresh write issues AW again.
